// File: rtl/zbb_pkg.sv
// Shared types for the Zbb operand-preparation stage.
package zbb_pkg;

    // Widest supported XLEN; narrower builds zero-extend into these fields.
    localparam int unsigned XLEN_MAX = 64;
    localparam int unsigned ZBBSEL_W = 3;

    // One prepared operand bundle, used for both the main and skid entries.
    typedef struct packed {
        logic [XLEN_MAX-1:0] a;
        logic [XLEN_MAX-1:0] rev_a;
        logic [XLEN_MAX-1:0] b;
        logic                w64;
        logic                lt;
        logic                ltu;
        logic                b_unsigned;
        logic [ZBBSEL_W-1:0] zbb_select;
    } zbb_opbundle_t;

    // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b10,
        StFull  = 2'b11
    } zbb_state_e;

endpackage

// File: rtl/zbb_opcalc.sv
// Input-side precompute: bit-reversed A plus signed/unsigned full-width A < B.
module zbb_opcalc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] rev_a_o,
    output logic             lt_o,
    output logic             ltu_o
);

    // Reverse A and compare at full width; *W variants never use these flags.
    always_comb begin
        rev_a_o = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            rev_a_o[i] = a_i[int'(WIDTH) - 1 - i];
        end
        lt_o  = $signed(a_i) < $signed(b_i);
        ltu_o = a_i < b_i;
    end

endmodule

// File: rtl/zbb_opstage.sv
// Registered operand stage ahead of the Zbb unit, with a 2-entry skid buffer so
// that InReady comes straight from a flop while still sustaining 1 txn/cycle.
module zbb_opstage
    import zbb_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                InValid,
    output logic                InReady,
    input  logic [WIDTH-1:0]    InA,
    input  logic [WIDTH-1:0]    InB,
    input  logic                InW64,
    input  logic                InBUnsigned,
    input  logic [ZBBSEL_W-1:0] InZBBSelect,
    input  logic                Flush,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [WIDTH-1:0]    A,
    output logic [WIDTH-1:0]    RevA,
    output logic [WIDTH-1:0]    B,
    output logic                W64,
    output logic                LT,
    output logic                LTU,
    output logic                BUnsigned,
    output logic [ZBBSEL_W-1:0] ZBBSelect
);

    zbb_state_e    state_q, state_d;
    zbb_opbundle_t main_q, main_d;
    zbb_opbundle_t skid_q, skid_d;
    zbb_opbundle_t in_bundle;

    logic [WIDTH-1:0] calc_rev_a;
    logic             calc_lt;
    logic             calc_ltu;
    logic             in_fire;
    logic             out_fire;

    zbb_opcalc #(
        .WIDTH (WIDTH)
    ) u_opcalc (
        .a_i     (InA),
        .b_i     (InB),
        .rev_a_o (calc_rev_a),
        .lt_o    (calc_lt),
        .ltu_o   (calc_ltu)
    );

    assign OutValid = state_q[1];
    assign InReady  = ~state_q[0];
    assign in_fire  = InValid & InReady;
    assign out_fire = OutValid & OutReady;

    // Pack the incoming operands and precomputed flags into a bundle.
    always_comb begin
        in_bundle                  = '0;
        in_bundle.a[WIDTH-1:0]     = InA;
        in_bundle.rev_a[WIDTH-1:0] = calc_rev_a;
        in_bundle.b[WIDTH-1:0]     = InB;
        in_bundle.w64              = InW64;
        in_bundle.lt               = calc_lt;
        in_bundle.ltu              = calc_ltu;
        in_bundle.b_unsigned       = InBUnsigned;
        in_bundle.zbb_select       = InZBBSelect;
    end

    // Next-state and entry loads; Flush overrides everything and drops InFire.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (Flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        main_d  = in_bundle;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_d = in_bundle;
                    end else if (in_fire) begin
                        skid_d  = in_bundle;
                        state_d = StFull;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    // InReady is low here, so only a drain can happen.
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Main and skid data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign A         = main_q.a[WIDTH-1:0];
    assign RevA      = main_q.rev_a[WIDTH-1:0];
    assign B         = main_q.b[WIDTH-1:0];
    assign W64       = main_q.w64;
    assign LT        = main_q.lt;
    assign LTU       = main_q.ltu;
    assign BUnsigned = main_q.b_unsigned;
    assign ZBBSelect = main_q.zbb_select;

    // Upper bits above WIDTH are always zero when WIDTH < XLEN_MAX.
    logic unused_hi;
    assign unused_hi = ^{main_q.a, main_q.rev_a, main_q.b};

endmodule
